// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR feed controller and its coefficient serializer.
package fir_pkg;
  localparam int X_N_SIZE       = 6;
  localparam int TAP_SIZE       = 2;
  localparam int NBR_OF_TAPS    = 8;
  localparam int CHUNKS         = 3;
  localparam int COEFF_W        = TAP_SIZE * NBR_OF_TAPS;
  localparam int TAPS_PER_CHUNK = X_N_SIZE / TAP_SIZE;

  typedef enum logic [2:0] {
    ST_SETUP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_STREAM = 3'd2,
    ST_LOAD   = 3'd3,
    ST_GAP    = 3'd4
  } fir_state_t;

  // Chunk idx carries taps 3*(2-idx) .. 3*(2-idx)+2, MSB field first; taps past 7 pad with 0.
  function automatic logic [X_N_SIZE-1:0] coeff_chunk(input logic [COEFF_W-1:0] v,
                                                       input logic [1:0] idx);
    logic [X_N_SIZE-1:0] c;
    int k;
    c = '0;
    for (int j = 0; j < TAPS_PER_CHUNK; j++) begin
      k = TAPS_PER_CHUNK * (CHUNKS - 1 - int'(idx)) + j;
      if (k >= 0 && k < NBR_OF_TAPS)
        c[X_N_SIZE-1-TAP_SIZE*j -: TAP_SIZE] = v[TAP_SIZE*k +: TAP_SIZE];
    end
    return c;
  endfunction
endpackage

// File: rtl/fir_coeff_serializer.sv
// Latches a coefficient vector and presents chunks C0..C2 one per cycle, a cycle ahead of the FIR pins.
module fir_coeff_serializer
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [COEFF_W-1:0]  coeffs,
  output logic [X_N_SIZE-1:0] chunk,
  output logic                set_coeffs,
  output logic                done
);
  logic [COEFF_W-1:0] coeffs_q;
  logic [1:0]         idx_q;
  logic               active_q;

  // On start the first chunk comes straight from the input so the caller can register it that edge.
  assign chunk      = start ? coeff_chunk(coeffs, 2'd0) : coeff_chunk(coeffs_q, idx_q);
  assign set_coeffs = start | active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      coeffs_q <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= active_q && (idx_q == 2'(CHUNKS - 1));
      if (start) begin
        coeffs_q <= coeffs;
        idx_q    <= 2'd1;
        active_q <= 1'b1;
      end else if (active_q) begin
        if (idx_q == 2'(CHUNKS - 1)) begin
          idx_q    <= '0;
          active_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end
    end
  end
endmodule

// File: rtl/fir_feed_ctrl.sv
// Upstream driver for the 8-tap FIR: setup window, sample forwarding and coefficient loads.
//   state  | meaning
//   SETUP  | post-reset window, FIR not yet ready
//   IDLE   | no sample on the FIR pins last cycle
//   STREAM | forwarding samples back-to-back
//   LOAD   | three coefficient chunks on x_n with s_set_coeffs
//   GAP    | one quiet cycle before streaming may resume
module fir_feed_ctrl
  import fir_pkg::*;
#(
  parameter int SETUP_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic [COEFF_W-1:0]  cfg_coeffs,
  output logic                cfg_busy,
  input  logic [X_N_SIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                s_set_coeffs,
  output logic                s_axis_fir_tvalid,
  output logic [CNT_W-1:0]    sample_cnt
);
  localparam int SW = $clog2(SETUP_CYCLES + 1);

  fir_state_t            state;
  logic [SW-1:0]         setup_cnt;
  logic                  open_st;
  logic                  ser_start;
  logic [X_N_SIZE-1:0]   ser_chunk;
  logic                  ser_set;
  logic                  ser_done;

  assign open_st   = (state == ST_IDLE) || (state == ST_STREAM);
  assign in_ready  = open_st && !cfg_start;
  assign ser_start = open_st && cfg_start;
  assign cfg_busy  = (state == ST_LOAD) || (state == ST_GAP);

  fir_coeff_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .start      (ser_start),
    .coeffs     (cfg_coeffs),
    .chunk      (ser_chunk),
    .set_coeffs (ser_set),
    .done       (ser_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_SETUP;
      setup_cnt         <= '0;
      x_n               <= '0;
      s_set_coeffs      <= 1'b0;
      s_axis_fir_tvalid <= 1'b0;
      sample_cnt        <= '0;
    end else begin
      case (state)
        ST_SETUP: begin
          x_n               <= '0;
          s_set_coeffs      <= 1'b0;
          s_axis_fir_tvalid <= 1'b0;
          if (setup_cnt == SW'(SETUP_CYCLES - 1)) state <= ST_IDLE;
          else setup_cnt <= setup_cnt + 1'b1;
        end
        ST_IDLE, ST_STREAM: begin
          if (cfg_start) begin
            x_n               <= ser_chunk;
            s_set_coeffs      <= ser_set;
            s_axis_fir_tvalid <= 1'b0;
            state             <= ST_LOAD;
          end else if (in_valid) begin
            x_n               <= in_data;
            s_set_coeffs      <= 1'b0;
            s_axis_fir_tvalid <= 1'b1;
            sample_cnt        <= sample_cnt + CNT_W'(1);
            state             <= ST_STREAM;
          end else begin
            // A bubble ends the FIR stream; it clears its history on its side.
            x_n               <= '0;
            s_set_coeffs      <= 1'b0;
            s_axis_fir_tvalid <= 1'b0;
            state             <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          x_n               <= ser_set ? ser_chunk : '0;
          s_set_coeffs      <= ser_set;
          s_axis_fir_tvalid <= 1'b0;
          if (ser_done) state <= ST_GAP;
        end
        ST_GAP: begin
          x_n               <= '0;
          s_set_coeffs      <= 1'b0;
          s_axis_fir_tvalid <= 1'b0;
          state             <= ST_IDLE;
        end
        default: begin
          x_n               <= '0;
          s_set_coeffs      <= 1'b0;
          s_axis_fir_tvalid <= 1'b0;
          setup_cnt         <= '0;
          state             <= ST_SETUP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_feed_ctrl.sv
// Self-checking bench for fir_feed_ctrl: directed scenarios plus random traffic against a transaction model.
module tb_fir_feed_ctrl;
  localparam int SETUP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic [15:0] cfg_coeffs;
  logic        cfg_busy;
  logic [5:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  x_n;
  logic        s_set_coeffs;
  logic        s_axis_fir_tvalid;
  logic [15:0] sample_cnt;

  always #5 clk = ~clk;

  fir_feed_ctrl #(.SETUP_CYCLES(SETUP), .CNT_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_start         (cfg_start),
    .cfg_coeffs        (cfg_coeffs),
    .cfg_busy          (cfg_busy),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .x_n               (x_n),
    .s_set_coeffs      (s_set_coeffs),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .sample_cnt        (sample_cnt)
  );

  typedef struct packed {logic set; logic [5:0] x;} ent_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          setup_left = SETUP;
  logic        busy_now = 1'b0;
  ent_t        lq[$];
  ent_t        e;
  logic [5:0]  exp_x = '0;
  logic        exp_tv = 1'b0;
  logic        exp_set = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] load_vec = '0;
  logic [5:0]  fir_c[3];
  int          fir_n = 0;
  logic [15:0] fir_taps;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_chunk(input logic [15:0] v, input int i);
    logic [1:0] t[8];
    for (int k = 0; k < 8; k++) t[k] = v[2*k +: 2];
    case (i)
      0:       return {t[6], t[7], 2'b00};
      1:       return {t[3], t[4], t[5]};
      default: return {t[0], t[1], t[2]};
    endcase
  endfunction

  // Downstream FIR: rebuild tap0..tap7 from the three chunks it captured.
  task automatic fir_observe();
    if (s_set_coeffs) begin
      fir_c[fir_n] = x_n;
      fir_n++;
      if (fir_n == 3) begin
        fir_taps = {fir_c[0][3:2], fir_c[0][5:4],
                    fir_c[1][1:0], fir_c[1][3:2], fir_c[1][5:4],
                    fir_c[2][1:0], fir_c[2][3:2], fir_c[2][5:4]};
        chk("fir_taps", fir_taps, load_vec);
        fir_n = 0;
      end
    end else begin
      fir_n = 0;
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [5:0] d,
                       input logic st, input logic [15:0] co);
    reset = rst; in_valid = v; in_data = d; cfg_start = st; cfg_coeffs = co;
    #1;
    chk("in_ready", in_ready, (setup_left == 0 && !busy_now && !st));
    chk("cfg_busy", cfg_busy, busy_now);
    if (rst) begin
      setup_left = SETUP; busy_now = 1'b0; lq.delete();
      exp_x = '0; exp_tv = 1'b0; exp_set = 1'b0; exp_cnt = '0;
    end else if (setup_left > 0) begin
      setup_left--;
      exp_x = '0; exp_tv = 1'b0; exp_set = 1'b0;
    end else if (busy_now) begin
      exp_tv = 1'b0;
      if (lq.size() > 0) begin
        e = lq.pop_front();
        exp_set = e.set; exp_x = e.x;
      end else begin
        busy_now = 1'b0; exp_set = 1'b0; exp_x = '0;
      end
    end else if (st) begin
      load_vec = co;
      lq.push_back('{1'b1, exp_chunk(co, 1)});
      lq.push_back('{1'b1, exp_chunk(co, 2)});
      lq.push_back('{1'b0, 6'd0});
      exp_x = exp_chunk(co, 0); exp_set = 1'b1; exp_tv = 1'b0; busy_now = 1'b1;
    end else if (v) begin
      exp_x = d; exp_tv = 1'b1; exp_set = 1'b0; exp_cnt = exp_cnt + 16'd1;
    end else begin
      exp_x = '0; exp_tv = 1'b0; exp_set = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("x_n", x_n, exp_x);
    chk("tvalid", s_axis_fir_tvalid, exp_tv);
    chk("set_coeffs", s_set_coeffs, exp_set);
    chk("sample_cnt", sample_cnt, exp_cnt);
    chk("excl", s_set_coeffs & s_axis_fir_tvalid, 1'b0);
    fir_observe();
  endtask

  initial begin
    // Reset, then in_valid held high through the setup window.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_x_n", x_n, 0);
    chk("rst_cnt", sample_cnt, 0);
    for (int i = 0; i < SETUP; i++) cycle(0, 1, 6'd5, 0, 0);
    cycle(0, 1, 6'd5, 0, 0);
    cycle(0, 1, 6'h3D, 0, 0);
    cycle(0, 1, 6'd7, 0, 0);
    chk("cnt_after3", sample_cnt, 3);
    cycle(0, 0, 0, 0, 0);
    chk("tvalid_drop", s_axis_fir_tvalid, 0);

    // Coefficient load from IDLE.
    cycle(0, 0, 0, 1, 16'h1B4E);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 16'h1B4E);

    // cfg_start collides with a sample mid-stream; sample held until after GAP.
    cycle(0, 1, 6'd11, 0, 0);
    cycle(0, 1, 6'd12, 1, 16'hA5C3);
    for (int i = 0; i < 6; i++) cycle(0, 1, 6'd12, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Repeated cfg_start during LOAD, then reset on the second load cycle.
    cycle(0, 0, 0, 1, 16'h3C69);
    cycle(0, 0, 0, 1, 16'hFFFF);
    cycle(1, 0, 0, 1, 16'hFFFF);
    chk("rst_mid_set", s_set_coeffs, 0);
    chk("rst_mid_x", x_n, 0);
    for (int i = 0; i < SETUP + 1; i++) cycle(0, 1, 6'd3, 0, 0);
    cycle(0, 0, 0, 1, 16'h3C69);
    cycle(0, 0, 0, 1, 16'h1111);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 16'h2222);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 6'($urandom),
            $urandom_range(0, 15) == 0, 16'($urandom));

    // Counter wrap.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < SETUP; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) cycle(0, 1, 6'(i), 0, 0);
    chk("cnt_ffff", sample_cnt, 16'hFFFF);
    cycle(0, 1, 6'd1, 0, 0);
    chk("cnt_wrap", sample_cnt, 0);
    cycle(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
